// File: rtl/dmx_uart_rx_if.sv
// Output bundle from the DMX512 receiver to the byte/break-to-USB formatter.
// o_FrameError exists only when DMX_RX_FRAMING_ERR_EN is defined.
interface dmx_uart_rx_if;
    logic       o_Rx_DataReady;
    logic [7:0] o_RxData;
    logic       o_RxBreak;
`ifdef DMX_RX_FRAMING_ERR_EN
    logic       o_FrameError;

    modport master (
        output o_Rx_DataReady,
        output o_RxData,
        output o_RxBreak,
        output o_FrameError
    );
    modport slave (
        input  o_Rx_DataReady,
        input  o_RxData,
        input  o_RxBreak,
        input  o_FrameError
    );
`else
    modport master (
        output o_Rx_DataReady,
        output o_RxData,
        output o_RxBreak
    );
    modport slave (
        input  o_Rx_DataReady,
        input  o_RxData,
        input  o_RxBreak
    );
`endif
endinterface

// File: rtl/dmx_uart_rx.sv
// DMX512 receiver (250 kbaud 8N2, LSB first): one-clock pulses per valid slot byte and per BREAK.
// Optional DMX_RX_FRAMING_ERR_EN adds o_FrameError for a bad stop bit that is not a BREAK.
module dmx_uart_rx #(
    parameter int CLKS_PER_BIT = 192,
    parameter int BREAK_CLKS   = 4224
) (
    input  logic          i_Clock,
    input  logic          i_Reset_n,
    input  logic          i_RxSerial,
    dmx_uart_rx_if.master o_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BREAK_CLKS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BRK_MAX   = BW'(BREAK_CLKS);
    localparam logic [BW-1:0] BRK_LAST  = BW'(BREAK_CLKS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_STOP     = 3'd3;
    localparam logic [2:0] S_BRK_WAIT = 3'd4;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx_s;
    logic [2:0]    r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_dr;
    logic [BW-1:0] r_low_cnt;
    logic          r_brk;

    // Synchroniser resets to idle-high so a reset never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_RxSerial;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_dr      <= 1'b0;
        end else begin
            r_dr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= '0;
                    if (!w_rx_s)
                        r_state <= S_START;
                end
                S_START: begin
                    if (r_bit_cnt == HALF_LAST) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    // From mid-start, every full bit period lands on mid-bit.
                    if (r_bit_cnt == FULL_LAST) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7)
                            r_state <= S_STOP;
                        else
                            r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_bit_cnt == FULL_LAST) begin
                        r_bit_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_dr    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_BRK_WAIT;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                end
                S_BRK_WAIT: begin
                    if (w_rx_s)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Low-time counter saturates, so BREAK fires once per low period.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_low_cnt <= '0;
            r_brk     <= 1'b0;
        end else begin
            r_brk <= !w_rx_s && (r_low_cnt == BRK_LAST);
            if (w_rx_s)
                r_low_cnt <= '0;
            else if (r_low_cnt != BRK_MAX)
                r_low_cnt <= r_low_cnt + BW'(1);
        end
    end

    assign o_rx.o_Rx_DataReady = r_dr;
    assign o_rx.o_RxData       = r_data;
    assign o_rx.o_RxBreak      = r_brk;

`ifdef DMX_RX_FRAMING_ERR_EN
    logic r_fe;

    // Counter still holds the finished low period here; saturation means a BREAK was already reported.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n)
            r_fe <= 1'b0;
        else
            r_fe <= (r_state == S_BRK_WAIT) && w_rx_s && (r_low_cnt != BRK_MAX);
    end

    assign o_rx.o_FrameError = r_fe;
`endif

endmodule

// File: tb/tb_dmx_uart_rx.sv
// Bench for dmx_uart_rx: builds line waveforms, decodes them with a line-scanning model, compares pulses.
// BREAK_CLKS is 88 so that it exceeds 10 bit times and a 0x00 slot is never taken for a BREAK.
module tb_dmx_uart_rx;
    localparam int C = 8;
    localparam int H = C / 2;
    localparam int B = 88;
`ifdef DMX_RX_FRAMING_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    typedef struct {
        int         kind;   // 0 data, 1 break, 2 frame error
        int         cyc;
        logic [7:0] data;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    dmx_uart_rx_if bus ();

    dmx_uart_rx #(.CLKS_PER_BIT(C), .BREAK_CLKS(B)) dut (
        .i_Clock    (clk),
        .i_Reset_n  (rst_n),
        .i_RxSerial (rx),
        .o_rx       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    bit         ln_q[$];
    int         excl_cnt = 0;
    int         hold_cnt = 0;
    logic [7:0] prev_data = 8'h00;
    int         base, got0, excl0, hold0;

    always @(negedge clk) begin
        logic fe;
        fe = 1'b0;
`ifdef DMX_RX_FRAMING_ERR_EN
        fe = bus.o_FrameError;
`endif
        if (rst_n) begin
            if (bus.o_Rx_DataReady) got_q.push_back(ev_t'{0, cyc, bus.o_RxData});
            if (bus.o_RxBreak)      got_q.push_back(ev_t'{1, cyc, 8'h00});
            if (fe)                 got_q.push_back(ev_t'{2, cyc, 8'h00});
            if ((bus.o_Rx_DataReady && bus.o_RxBreak) || (fe && (bus.o_Rx_DataReady || bus.o_RxBreak)))
                excl_cnt++;
            if (!bus.o_Rx_DataReady && bus.o_RxData !== prev_data)
                hold_cnt++;
        end
        prev_data = bus.o_RxData;
    end

    task automatic add_lvl(input bit v, input int n);
        repeat (n) ln_q.push_back(v);
    endtask

    // nstop == 0 leaves the stop bits to the caller.
    task automatic add_frame(input logic [7:0] d, input int nstop);
        add_lvl(1'b0, C);
        for (int k = 0; k < 8; k++) add_lvl(d[k], C);
        add_lvl(1'b1, nstop * C);
    endtask

    // Decode the line as a UART would see it, two clocks late through the synchroniser.
    task automatic model();
        int n, run, i, t, j, e, r;
        logic [7:0] b;
        exp_q.delete();
        n = ln_q.size();
        run = 0;
        for (int k = 0; k < n; k++) begin
            if (!ln_q[k]) begin
                run++;
                if (run == B) exp_q.push_back(ev_t'{1, k + 2, 8'h00});
            end else begin
                run = 0;
            end
        end
        i = 0;
        while (i < n) begin
            if (ln_q[i]) begin
                i++;
            end else begin
                t = i;
                if (t + H + 9 * C >= n) break;
                if (ln_q[t + H]) begin
                    i = t + H + 1;
                end else begin
                    for (int k = 0; k < 8; k++) b[k] = ln_q[t + H + (k + 1) * C];
                    j = t + H + 9 * C;
                    if (ln_q[j]) begin
                        exp_q.push_back(ev_t'{0, j + 2, b});
                        i = j + 1;
                    end else begin
                        e = j;
                        while (e < n && !ln_q[e]) e++;
                        if (e >= n) break;
                        r = 0;
                        for (int m = e - 1; m >= 0 && !ln_q[m]; m--) r++;
                        if (FE_EN && r < B) exp_q.push_back(ev_t'{2, e + 2, 8'h00});
                        i = e + 1;
                    end
                end
            end
        end
    endtask

    task automatic run_line(input int tail);
        @(negedge clk);
        base  = cyc + 1;
        got0  = got_q.size();
        excl0 = excl_cnt;
        hold0 = hold_cnt;
        rx    = ln_q[0];
        for (int k = 1; k < ln_q.size(); k++) begin
            @(negedge clk);
            rx = ln_q[k];
        end
        repeat (tail) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    function automatic int cnt_kind(input int kind);
        int c = 0;
        for (int i = got0; i < got_q.size(); i++)
            if (got_q[i].kind == kind) c++;
        return c;
    endfunction

    task automatic check_events(input string name);
        ev_t g[$];
        ev_t ev;
        bit  found;
        for (int i = got0; i < got_q.size(); i++) begin
            ev = got_q[i];
            ev.cyc = ev.cyc - base;
            g.push_back(ev);
        end
        n_checks++;
        if (g.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL %s event_count: got %0d expected %0d", name, g.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            found = 1'b0;
            for (int j = 0; j < g.size() && !found; j++) begin
                if (g[j].kind == exp_q[i].kind && g[j].data === exp_q[i].data &&
                    g[j].cyc >= exp_q[i].cyc - 1 && g[j].cyc <= exp_q[i].cyc + 1) begin
                    found = 1'b1;
                    g.delete(j);
                end
            end
            n_checks++;
            if (!found) begin
                n_errors++;
                $display("FAIL %s event[%0d]: kind=%0d cyc=%0d data=%02h not observed", name, i,
                         exp_q[i].kind, exp_q[i].cyc, exp_q[i].data);
            end
        end
        n_checks++;
        if (excl_cnt - excl0 !== 0) begin
            n_errors++;
            $display("FAIL %s overlap: got %0d overlapping pulses expected 0", name, excl_cnt - excl0);
        end
        n_checks++;
        if (hold_cnt - hold0 !== 0) begin
            n_errors++;
            $display("FAIL %s data_hold: o_RxData changed %0d times without a pulse, expected 0", name, hold_cnt - hold0);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if (bus.o_Rx_DataReady !== 1'b0) begin
            n_errors++;
            $display("FAIL %s dr: got %b expected 0", name, bus.o_Rx_DataReady);
        end
        n_checks++;
        if (bus.o_RxData !== 8'h00) begin
            n_errors++;
            $display("FAIL %s data: got %02h expected 00", name, bus.o_RxData);
        end
        n_checks++;
        if (bus.o_RxBreak !== 1'b0) begin
            n_errors++;
            $display("FAIL %s brk: got %b expected 0", name, bus.o_RxBreak);
        end
`ifdef DMX_RX_FRAMING_ERR_EN
        n_checks++;
        if (bus.o_FrameError !== 1'b0) begin
            n_errors++;
            $display("FAIL %s fe: got %b expected 0", name, bus.o_FrameError);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        ln_q.delete();
        add_lvl(1'b1, 16); add_frame(8'hA5, 2); add_lvl(1'b1, 30);
        model(); run_line(4); check_events("single");
        n_checks++;
        if (cnt_kind(0) !== 1 || bus.o_RxData !== 8'hA5) begin
            n_errors++;
            $display("FAIL single direct: got %0d pulses data=%02h expected 1 pulse data=a5", cnt_kind(0), bus.o_RxData);
        end
    endtask

    task automatic test_break();
        ln_q.delete();
        add_lvl(1'b1, 16); add_lvl(1'b0, 100); add_lvl(1'b1, 30);
        model(); run_line(4); check_events("break");
        n_checks++;
        if (cnt_kind(1) !== 1 || cnt_kind(0) !== 0 || cnt_kind(2) !== 0) begin
            n_errors++;
            $display("FAIL break direct: got brk=%0d dr=%0d fe=%0d expected 1/0/0", cnt_kind(1), cnt_kind(0), cnt_kind(2));
        end
    endtask

    task automatic test_glitch();
        ln_q.delete();
        add_lvl(1'b1, 16); add_lvl(1'b0, 2); add_lvl(1'b1, 20); add_frame(8'h3C, 2); add_lvl(1'b1, 30);
        model(); run_line(4); check_events("glitch");
        n_checks++;
        if (cnt_kind(0) !== 1 || bus.o_RxData !== 8'h3C) begin
            n_errors++;
            $display("FAIL glitch direct: got %0d pulses data=%02h expected 1 pulse data=3c", cnt_kind(0), bus.o_RxData);
        end
    endtask

    task automatic test_framing();
        ln_q.delete();
        add_lvl(1'b1, 16); add_frame(8'h12, 0); add_lvl(1'b0, 20); add_lvl(1'b1, 30);
        model(); run_line(4); check_events("framing");
        n_checks++;
        if (cnt_kind(0) !== 0 || cnt_kind(1) !== 0 || cnt_kind(2) !== (FE_EN ? 1 : 0)) begin
            n_errors++;
            $display("FAIL framing direct: got dr=%0d brk=%0d fe=%0d expected 0/0/%0d", cnt_kind(0), cnt_kind(1), cnt_kind(2), FE_EN ? 1 : 0);
        end
    endtask

    task automatic test_packet();
        logic [7:0] want[3];
        int k;
        want[0] = 8'h00; want[1] = 8'hFF; want[2] = 8'h55;
        ln_q.delete();
        add_lvl(1'b1, 16); add_lvl(1'b0, 100); add_lvl(1'b1, 12 * C);
        for (int i = 0; i < 3; i++) add_frame(want[i], 2);
        add_lvl(1'b1, 30);
        model(); run_line(4); check_events("packet");
        k = 0;
        for (int i = got0; i < got_q.size(); i++) begin
            if (got_q[i].kind == 0) begin
                n_checks++;
                if (k > 2 || got_q[i].data !== want[k > 2 ? 2 : k]) begin
                    n_errors++;
                    $display("FAIL packet order[%0d]: got %02h expected %02h", k, got_q[i].data, want[k > 2 ? 2 : k]);
                end
                k++;
            end
        end
        n_checks++;
        if (k !== 3 || cnt_kind(1) !== 1) begin
            n_errors++;
            $display("FAIL packet counts: got dr=%0d brk=%0d expected 3/1", k, cnt_kind(1));
        end
    endtask

    task automatic test_random();
        int sel;
        for (int it = 0; it < 4; it++) begin
            ln_q.delete();
            add_lvl(1'b1, 16);
            for (int n = 0; n < 10; n++) begin
                sel = $urandom_range(0, 9);
                if (sel == 0) begin
                    add_lvl(1'b0, $urandom_range(1, 3)); add_lvl(1'b1, $urandom_range(C, 2 * C));
                end else if (sel == 1) begin
                    add_lvl(1'b0, B + $urandom_range(0, 40)); add_lvl(1'b1, $urandom_range(1, 3 * C));
                end else if (sel == 2) begin
                    add_frame(8'($urandom), 0); add_lvl(1'b0, $urandom_range(C, 3 * C));
                    add_lvl(1'b1, $urandom_range(1, 2 * C));
                end else begin
                    add_frame(8'($urandom), $urandom_range(1, 2)); add_lvl(1'b1, $urandom_range(0, C));
                end
            end
            add_lvl(1'b1, 30);
            model(); run_line(4); check_events($sformatf("random%0d", it));
        end
    endtask

    task automatic test_back_to_back();
        ln_q.delete();
        add_lvl(1'b1, 16);
        for (int n = 0; n < 12; n++) add_frame(8'($urandom), $urandom_range(1, 2));
        add_lvl(1'b1, 30);
        model(); run_line(4); check_events("back_to_back");
        n_checks++;
        if (cnt_kind(0) !== 12) begin
            n_errors++;
            $display("FAIL back_to_back count: got %0d expected 12", cnt_kind(0));
        end
    endtask

    task automatic test_reset_mid();
        ln_q.delete();
        add_lvl(1'b1, 16); add_frame(8'h5A, 2); add_lvl(1'b1, 8);
        add_lvl(1'b0, C); add_lvl(1'b1, 4 * C + H + 2);
        model(); run_line(0); check_events("reset_mid_pre");
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check_outputs_zero("reset_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ln_q.delete();
        add_lvl(1'b1, 16); add_frame(8'h00, 2); add_lvl(1'b1, 30);
        model(); run_line(4); check_events("reset_mid_post");
        n_checks++;
        if (cnt_kind(0) !== 1 || bus.o_RxData !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid_post direct: got %0d pulses data=%02h expected 1 pulse data=00", cnt_kind(0), bus.o_RxData);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_break();
        test_glitch();
        test_framing();
        test_packet();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
